// File: rtl/alu_sched_if.sv
// rtl/alu_sched_if.sv - request, alu issue/return and response signal bundle for alu_sched
interface alu_sched_if #(
    parameter int DATA_W = 8,
    parameter int INST_W = 3
);
    logic              i_req0_valid;
    logic              o_req0_ready;
    logic [DATA_W-1:0] i_req0_data_a;
    logic [DATA_W-1:0] i_req0_data_b;
    logic [INST_W-1:0] i_req0_inst;
    logic              i_req1_valid;
    logic              o_req1_ready;
    logic [DATA_W-1:0] i_req1_data_a;
    logic [DATA_W-1:0] i_req1_data_b;
    logic [INST_W-1:0] i_req1_inst;

    logic              o_alu_valid;
    logic [DATA_W-1:0] o_alu_data_a;
    logic [DATA_W-1:0] o_alu_data_b;
    logic [INST_W-1:0] o_alu_inst;
    logic              i_alu_valid;
    logic [DATA_W-1:0] i_alu_data;

    logic              o_rsp0_valid;
    logic [DATA_W-1:0] o_rsp0_data;
    logic              i_rsp0_ready;
    logic              o_rsp1_valid;
    logic [DATA_W-1:0] o_rsp1_data;
    logic              i_rsp1_ready;

    logic              o_err;

    modport slave (
        input  i_req0_valid, i_req0_data_a, i_req0_data_b, i_req0_inst,
        input  i_req1_valid, i_req1_data_a, i_req1_data_b, i_req1_inst,
        output o_req0_ready, o_req1_ready,
        output o_alu_valid, o_alu_data_a, o_alu_data_b, o_alu_inst,
        input  i_alu_valid, i_alu_data,
        output o_rsp0_valid, o_rsp0_data, o_rsp1_valid, o_rsp1_data,
        input  i_rsp0_ready, i_rsp1_ready,
        output o_err
    );

    modport master (
        output i_req0_valid, i_req0_data_a, i_req0_data_b, i_req0_inst,
        output i_req1_valid, i_req1_data_a, i_req1_data_b, i_req1_inst,
        input  o_req0_ready, o_req1_ready,
        input  o_alu_valid, o_alu_data_a, o_alu_data_b, o_alu_inst,
        output i_alu_valid, i_alu_data,
        input  o_rsp0_valid, o_rsp0_data, o_rsp1_valid, o_rsp1_data,
        output i_rsp0_ready, i_rsp1_ready,
        input  o_err
    );
endinterface

// File: rtl/alu_sched.sv
// rtl/alu_sched.sv - two-port round-robin scheduler feeding one alu, with credit-limited per-port response FIFOs
module alu_sched #(
    parameter int DATA_W    = 8,
    parameter int INST_W    = 3,
    parameter int RSP_DEPTH = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    alu_sched_if.slave bus
);
    localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CNT_W = $clog2(RSP_DEPTH + 1);
    localparam int SUM_W = CNT_W + 1;
    localparam logic [SUM_W-1:0] DEPTH_L = SUM_W'(RSP_DEPTH);

    logic [1:0]        req_v;
    logic [1:0]        rsp_rdy;
    logic [DATA_W-1:0] req_a    [2];
    logic [DATA_W-1:0] req_b    [2];
    logic [INST_W-1:0] req_inst [2];

    assign req_v       = {bus.i_req1_valid, bus.i_req0_valid};
    assign rsp_rdy     = {bus.i_rsp1_ready, bus.i_rsp0_ready};
    assign req_a[0]    = bus.i_req0_data_a;
    assign req_a[1]    = bus.i_req1_data_a;
    assign req_b[0]    = bus.i_req0_data_b;
    assign req_b[1]    = bus.i_req1_data_b;
    assign req_inst[0] = bus.i_req0_inst;
    assign req_inst[1] = bus.i_req1_inst;

    logic              rr_q, rr_d;
    logic              alu_v_q;
    logic [DATA_W-1:0] alu_a_q, alu_b_q;
    logic [INST_W-1:0] alu_inst_q;
    logic              tag1_q;
    logic              s2_v_q, tag2_q;
    logic              err_q;

    logic [DATA_W-1:0] mem_q    [2][RSP_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q [2];
    logic [PTR_W-1:0]  rd_ptr_q [2];
    logic [CNT_W-1:0]  occ_q    [2];

    logic [1:0]        elig, gnt, push, pop, nonempty;
    logic [SUM_W-1:0]  used [2];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Credits: buffered results plus ops still in the alu pipe must fit the FIFO.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            used[p]     = {1'b0, occ_q[p]}
                        + SUM_W'(alu_v_q && (tag1_q == 1'(p)))
                        + SUM_W'(s2_v_q && (tag2_q == 1'(p)));
            elig[p]     = req_v[p] && (used[p] < DEPTH_L);
            nonempty[p] = (occ_q[p] != '0);
            push[p]     = bus.i_alu_valid && s2_v_q && (tag2_q == 1'(p));
            pop[p]      = nonempty[p] && rsp_rdy[p];
        end
    end

    always_comb begin
        gnt = 2'b00;
        if (!i_rst) begin
            gnt[0] = elig[0] && (!elig[1] || !rr_q);
            gnt[1] = elig[1] && (!elig[0] || rr_q);
        end
        rr_d = rr_q;
        if (gnt[0]) begin
            rr_d = 1'b1;
        end else if (gnt[1]) begin
            rr_d = 1'b0;
        end
    end

    assign bus.o_req0_ready = gnt[0];
    assign bus.o_req1_ready = gnt[1];
    assign bus.o_alu_valid  = alu_v_q;
    assign bus.o_alu_data_a = alu_a_q;
    assign bus.o_alu_data_b = alu_b_q;
    assign bus.o_alu_inst   = alu_inst_q;
    assign bus.o_rsp0_valid = nonempty[0] && !i_rst;
    assign bus.o_rsp1_valid = nonempty[1] && !i_rst;
    assign bus.o_rsp0_data  = mem_q[0][rd_ptr_q[0]];
    assign bus.o_rsp1_data  = mem_q[1][rd_ptr_q[1]];
    assign bus.o_err        = err_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rr_q       <= 1'b0;
            alu_v_q    <= 1'b0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_inst_q <= '0;
            tag1_q     <= 1'b0;
            s2_v_q     <= 1'b0;
            tag2_q     <= 1'b0;
            err_q      <= 1'b0;
            for (int p = 0; p < 2; p++) begin
                wr_ptr_q[p] <= '0;
                rd_ptr_q[p] <= '0;
                occ_q[p]    <= '0;
            end
        end else begin
            rr_q    <= rr_d;
            alu_v_q <= |gnt;
            tag1_q  <= gnt[1];
            if (|gnt) begin
                alu_a_q    <= req_a[gnt[1]];
                alu_b_q    <= req_b[gnt[1]];
                alu_inst_q <= req_inst[gnt[1]];
            end
            s2_v_q <= alu_v_q;
            tag2_q <= tag1_q;
            // A result with no matching issue, or an issue with no result, is unrecoverable.
            if (bus.i_alu_valid != s2_v_q) begin
                err_q <= 1'b1;
            end
            for (int p = 0; p < 2; p++) begin
                if (push[p]) begin
                    wr_ptr_q[p] <= ptr_inc(wr_ptr_q[p]);
                end
                if (pop[p]) begin
                    rd_ptr_q[p] <= ptr_inc(rd_ptr_q[p]);
                end
                case ({push[p], pop[p]})
                    2'b10:   occ_q[p] <= occ_q[p] + 1'b1;
                    2'b01:   occ_q[p] <= occ_q[p] - 1'b1;
                    default: occ_q[p] <= occ_q[p];
                endcase
            end
        end
    end

    always_ff @(posedge i_clk) begin
        for (int p = 0; p < 2; p++) begin
            if (push[p]) begin
                mem_q[p][wr_ptr_q[p]] <= bus.i_alu_data;
            end
        end
    end
endmodule

// File: tb/tb_alu_sched.sv
// tb/tb_alu_sched.sv - directed table and sequence bench for alu_sched with a one-cycle alu model
module tb_alu_sched;
    localparam int DATA_W    = 8;
    localparam int INST_W    = 3;
    localparam int RSP_DEPTH = 4;

    localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4, OP_MIN = 3'd5, OP_MAX = 3'd6, OP_PSA = 3'd7;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_sched_if #(.DATA_W(DATA_W), .INST_W(INST_W)) bus ();

    alu_sched #(.DATA_W(DATA_W), .INST_W(INST_W), .RSP_DEPTH(RSP_DEPTH)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    function automatic logic [7:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_MIN:  return (a < b) ? a : b;
            OP_MAX:  return (a > b) ? a : b;
            default: return a;
        endcase
    endfunction

    logic       alu_v_q;
    logic [7:0] alu_d_q;
    logic       inj;

    always @(posedge clk) begin
        if (rst) begin
            alu_v_q <= 1'b0;
            alu_d_q <= 8'h00;
        end else begin
            alu_v_q <= bus.o_alu_valid;
            alu_d_q <= alu_f(bus.o_alu_inst, bus.o_alu_data_a, bus.o_alu_data_b);
        end
    end

    assign bus.i_alu_valid = alu_v_q | inj;
    assign bus.i_alu_data  = alu_d_q;

    typedef struct {
        logic       port;
        logic [2:0] inst;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] y;
    } vec_t;

    vec_t       vt [8];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp0 [$];
    logic [7:0] exp1 [$];
    int         gnt_hist [$];
    int         got0, got1, seen_rsp;
    logic [7:0] cnt0, cnt1, b0;
    logic [2:0] op0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_sb();
        exp0.delete();
        exp1.delete();
        gnt_hist.delete();
        got0 = 0; got1 = 0; seen_rsp = 0;
        cnt0 = 8'h00; cnt1 = 8'h00;
    endtask

    task automatic idle_inputs();
        bus.i_req0_valid = 1'b0;
        bus.i_req1_valid = 1'b0;
        bus.i_rsp0_ready = 1'b1;
        bus.i_rsp1_ready = 1'b1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_sb();
    endtask

    // Port 0 issues op0(cnt0, b0); port 1 issues SUB(0x80, cnt1); both counters advance per accept.
    task automatic run(input int n, input logic v0, input logic v1, input logic r1);
        for (int c = 0; c < n; c++) begin
            int g;
            bus.i_req0_valid  = v0;
            bus.i_req0_data_a = cnt0;
            bus.i_req0_data_b = b0;
            bus.i_req0_inst   = op0;
            bus.i_req1_valid  = v1;
            bus.i_req1_data_a = 8'h80;
            bus.i_req1_data_b = cnt1;
            bus.i_req1_inst   = OP_SUB;
            bus.i_rsp0_ready  = 1'b1;
            bus.i_rsp1_ready  = r1;
            @(negedge clk);
            chk("single_grant", 32'(bus.o_req0_ready & bus.o_req1_ready), 0);
            g = bus.o_req0_ready ? 0 : (bus.o_req1_ready ? 1 : -1);
            gnt_hist.push_back(g);
            if (g == 0) exp0.push_back(alu_f(op0, cnt0, b0));
            if (g == 1) exp1.push_back(8'(8'h80 - cnt1));
            if (bus.o_rsp0_valid) begin
                seen_rsp++;
                if (exp0.size() == 0) chk("rsp0_unexpected", 32'(exp0.size()), 1);
                else begin
                    chk("rsp0_data", bus.o_rsp0_data, exp0.pop_front());
                    got0++;
                end
            end
            if (bus.o_rsp1_valid) begin
                seen_rsp++;
                if (r1) begin
                    if (exp1.size() == 0) chk("rsp1_unexpected", 32'(exp1.size()), 1);
                    else begin
                        chk("rsp1_data", bus.o_rsp1_data, exp1.pop_front());
                        got1++;
                    end
                end
            end
            tick();
            if (g == 0) cnt0++;
            if (g == 1) cnt1++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int n1;
        vt[0] = '{1'b0, OP_ADD, 8'h10, 8'h08, 8'h18};
        vt[1] = '{1'b1, OP_SUB, 8'h05, 8'h07, 8'hFE};
        vt[2] = '{1'b0, OP_AND, 8'hF0, 8'h3C, 8'h30};
        vt[3] = '{1'b1, OP_OR,  8'hF0, 8'h0F, 8'hFF};
        vt[4] = '{1'b0, OP_XOR, 8'hAA, 8'hFF, 8'h55};
        vt[5] = '{1'b1, OP_MIN, 8'h80, 8'h7F, 8'h7F};
        vt[6] = '{1'b0, OP_MAX, 8'h01, 8'hFE, 8'hFE};
        vt[7] = '{1'b1, OP_ADD, 8'hFF, 8'h01, 8'h00};

        inj = 1'b0;
        op0 = OP_ADD;
        b0  = 8'h10;
        clear_sb();
        idle_inputs();
        bus.i_req0_data_a = 8'h11; bus.i_req0_data_b = 8'h22; bus.i_req0_inst = OP_PSA;
        bus.i_req1_data_a = 8'h33; bus.i_req1_data_b = 8'h44; bus.i_req1_inst = OP_PSA;

        // Reset state, with requests asserted to prove reset masks the grant.
        tick();
        bus.i_req0_valid = 1'b1;
        bus.i_req1_valid = 1'b1;
        @(negedge clk);
        chk("rst_req0_ready", bus.o_req0_ready, 0);
        chk("rst_req1_ready", bus.o_req1_ready, 0);
        chk("rst_rsp0_valid", bus.o_rsp0_valid, 0);
        chk("rst_rsp1_valid", bus.o_rsp1_valid, 0);
        tick();
        @(negedge clk);
        chk("rst_alu_valid", bus.o_alu_valid, 0);
        chk("rst_alu_a", bus.o_alu_data_a, 0);
        chk("rst_alu_b", bus.o_alu_data_b, 0);
        chk("rst_alu_inst", bus.o_alu_inst, 0);
        chk("rst_err", bus.o_err, 0);
        tick();
        do_reset();

        // Table: one op at a time, checking issue and the 3-cycle response latency.
        for (int i = 0; i < 8; i++) begin
            idle_inputs();
            if (vt[i].port) begin
                bus.i_req1_valid = 1'b1; bus.i_req1_data_a = vt[i].a;
                bus.i_req1_data_b = vt[i].b; bus.i_req1_inst = vt[i].inst;
            end else begin
                bus.i_req0_valid = 1'b1; bus.i_req0_data_a = vt[i].a;
                bus.i_req0_data_b = vt[i].b; bus.i_req0_inst = vt[i].inst;
            end
            @(negedge clk);
            chk($sformatf("tbl%0d_ready", i), vt[i].port ? bus.o_req1_ready : bus.o_req0_ready, 1);
            tick();
            idle_inputs();
            @(negedge clk);
            chk($sformatf("tbl%0d_alu_valid", i), bus.o_alu_valid, 1);
            chk($sformatf("tbl%0d_alu_a", i), bus.o_alu_data_a, vt[i].a);
            chk($sformatf("tbl%0d_alu_inst", i), bus.o_alu_inst, vt[i].inst);
            tick();
            @(negedge clk);
            chk($sformatf("tbl%0d_rsp_early", i), vt[i].port ? bus.o_rsp1_valid : bus.o_rsp0_valid, 0);
            tick();
            @(negedge clk);
            chk($sformatf("tbl%0d_rsp_valid", i), vt[i].port ? bus.o_rsp1_valid : bus.o_rsp0_valid, 1);
            chk($sformatf("tbl%0d_rsp_data", i), vt[i].port ? bus.o_rsp1_data : bus.o_rsp0_data, vt[i].y);
            chk($sformatf("tbl%0d_err", i), bus.o_err, 0);
            tick();
        end

        // Contention: grants alternate starting from port 0.
        do_reset();
        op0 = OP_ADD; b0 = 8'h10;
        run(12, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 12; i++) chk($sformatf("rr_grant%0d", i), 32'(gnt_hist[i]), 32'(i % 2));
        run(6, 1'b0, 1'b0, 1'b1);
        chk("rr_got0", 32'(got0), 6);
        chk("rr_got1", 32'(got1), 6);
        chk("rr_err", bus.o_err, 0);

        // Backpressure on port 1: four credits, then port 0 alone every cycle.
        do_reset();
        run(20, 1'b1, 1'b1, 1'b0);
        n1 = 0;
        foreach (gnt_hist[i]) if (gnt_hist[i] == 1) n1++;
        chk("bp_req1_accepts", 32'(n1), 4);
        for (int i = 8; i < 20; i++) chk($sformatf("bp_grant%0d", i), 32'(gnt_hist[i]), 0);
        chk("bp_rsp1_held", bus.o_rsp1_valid, 1);
        run(8, 1'b0, 1'b0, 1'b1);
        chk("bp_drain1", 32'(got1), 4);
        chk("bp_drain0", 32'(got0), 16);

        // Streaming: 16 back-to-back MIN ops on port 0.
        do_reset();
        op0 = OP_MIN; b0 = 8'h08;
        run(16, 1'b1, 1'b0, 1'b1);
        n1 = 0;
        foreach (gnt_hist[i]) if (gnt_hist[i] == 0) n1++;
        chk("stream_accepts", 32'(n1), 16);
        run(4, 1'b0, 1'b0, 1'b1);
        chk("stream_results", 32'(got0), 16);

        // Error: spurious alu result with nothing issued.
        do_reset();
        tick();
        @(negedge clk);
        chk("err_before", bus.o_err, 0);
        tick();
        inj = 1'b1;
        tick();
        inj = 1'b0;
        @(negedge clk);
        chk("err_set", bus.o_err, 1);
        tick(); tick();
        @(negedge clk);
        chk("err_sticky", bus.o_err, 1);
        chk("err_no_push0", bus.o_rsp0_valid, 0);
        chk("err_no_push1", bus.o_rsp1_valid, 0);
        do_reset();
        @(negedge clk);
        chk("err_cleared", bus.o_err, 0);
        tick();

        // Mid-op reset one cycle after two accepts.
        do_reset();
        op0 = OP_ADD; b0 = 8'h10;
        run(2, 1'b1, 1'b1, 1'b1);
        chk("mid_grant0", 32'(gnt_hist[0]), 0);
        chk("mid_grant1", 32'(gnt_hist[1]), 1);
        do_reset();
        run(6, 1'b0, 1'b0, 1'b1);
        chk("mid_no_rsp", 32'(seen_rsp), 0);
        gnt_hist.delete();
        run(1, 1'b1, 1'b1, 1'b1);
        chk("mid_first_grant", 32'(gnt_hist[0]), 0);
        chk("mid_err", bus.o_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
